// File: rtl/quad_gate_bist_ctrl_pkg.sv
// Shared definitions for the quad 2-input gate BIST sequencer:
// state encoding, channel/pattern counts and gate truth-table constants.
package quad_gate_bist_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } bist_state_e;

    localparam int NUM_CH  = 4;
    localparam int NUM_PAT = 4;

    // Truth tables indexed by {A,B}: bit k is the gate output for {A,B} == k.
    localparam logic [3:0] FUNC_OR   = 4'b1110;
    localparam logic [3:0] FUNC_AND  = 4'b1000;
    localparam logic [3:0] FUNC_NAND = 4'b0111;
    localparam logic [3:0] FUNC_NOR  = 4'b0001;

    // Expected gate output for one {A,B} pattern.
    function automatic logic exp_bit(input logic [3:0] func, input logic [1:0] pat);
        return func[pat];
    endfunction

endpackage

// File: rtl/bist_result_acc.sv
// Result accumulator: compares sampled Y outputs with the expected bit,
// collects a sticky per-channel fail mask and latches the first failing pattern.
module bist_result_acc
    import quad_gate_bist_ctrl_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              check_i,
    input  logic [1:0]        pattern_i,
    input  logic              exp_i,
    input  logic [NUM_CH-1:0] y_i,
    output logic [NUM_CH-1:0] mismatch_o,
    output logic [NUM_CH-1:0] fail_mask_o,
    output logic [1:0]        first_fail_o
);

    logic [NUM_CH-1:0] fail_mask_q, fail_mask_d;
    logic [1:0]        first_fail_q, first_fail_d;
    logic              seen_q, seen_d;

    // Per-channel compare; anything other than a clean match (including X/Z) flags the channel.
    always_comb begin
        mismatch_o = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            mismatch_o[n] = (y_i[n] === exp_i) ? 1'b0 : 1'b1;
        end
    end

    // Next-state for the sticky results; clear has priority over a check strobe.
    always_comb begin
        fail_mask_d  = fail_mask_q;
        first_fail_d = first_fail_q;
        seen_d       = seen_q;
        if (clear_i) begin
            fail_mask_d  = '0;
            first_fail_d = 2'b00;
            seen_d       = 1'b0;
        end else if (check_i) begin
            fail_mask_d = fail_mask_q | mismatch_o;
            if ((mismatch_o != '0) && !seen_q) begin
                first_fail_d = pattern_i;
                seen_d       = 1'b1;
            end
        end
    end

    // Result registers, cleared asynchronously by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fail_mask_q  <= '0;
            first_fail_q <= 2'b00;
            seen_q       <= 1'b0;
        end else begin
            fail_mask_q  <= fail_mask_d;
            first_fail_q <= first_fail_d;
            seen_q       <= seen_d;
        end
    end

    assign fail_mask_o  = fail_mask_q;
    assign first_fail_o = first_fail_q;

endmodule

// File: rtl/quad_gate_bist_ctrl.sv
// BIST sequencer for a quad 2-input gate package: walks the four {A,B}
// patterns on all channels at once, settles, samples Y and reports results.
module quad_gate_bist_ctrl
    import quad_gate_bist_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,        // legal range 1..15
    parameter logic [3:0]  GATE_FUNC     = FUNC_OR
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    output logic [NUM_CH-1:0] o_a,
    output logic [NUM_CH-1:0] o_b,
    input  logic [NUM_CH-1:0] i_y,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [NUM_CH-1:0] o_fail_mask,
    output logic [1:0]        o_first_fail
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [1:0] LAST_PAT    = 2'(NUM_PAT - 1);

    bist_state_e       state_q, state_d;
    logic [1:0]        pat_q, pat_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [NUM_CH-1:0] a_q, a_d;
    logic [NUM_CH-1:0] b_q, b_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;

    logic              acc_clear;
    logic              acc_check;
    logic [1:0]        pat_nx;
    logic [NUM_CH-1:0] mismatch;
    logic [NUM_CH-1:0] fail_mask;
    logic [1:0]        first_fail;

    assign pat_nx = pat_q + 2'd1;

    // Next-state and registered-output logic; abort overrides everything.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        acc_clear = 1'b0;
        acc_check = 1'b0;
        if (i_abort) begin
            state_d   = ST_IDLE;
            pat_d     = 2'b00;
            cnt_d     = '0;
            a_d       = '0;
            b_d       = '0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            pass_d    = 1'b0;
            acc_clear = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        state_d   = ST_SETTLE;
                        pat_d     = 2'b00;
                        cnt_d     = '0;
                        a_d       = '0;
                        b_d       = '0;
                        busy_d    = 1'b1;
                        done_d    = 1'b0;
                        pass_d    = 1'b0;
                        acc_clear = 1'b1;
                    end
                end
                ST_SETTLE: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    acc_check = 1'b1;
                    cnt_d     = '0;
                    if (pat_q == LAST_PAT) begin
                        state_d = ST_DONE;
                        a_d     = '0;
                        b_d     = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = ((fail_mask | mismatch) == '0);
                    end else begin
                        state_d = ST_SETTLE;
                        pat_d   = pat_nx;
                        a_d     = {NUM_CH{pat_nx[1]}};
                        b_d     = {NUM_CH{pat_nx[0]}};
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Sequencer state and output registers with asynchronous reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            pat_q   <= 2'b00;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    bist_result_acc u_acc (
        .clk_i        (i_clk),
        .rst_ni       (i_rst_n),
        .clear_i      (acc_clear),
        .check_i      (acc_check),
        .pattern_i    (pat_q),
        .exp_i        (exp_bit(GATE_FUNC, pat_q)),
        .y_i          (i_y),
        .mismatch_o   (mismatch),
        .fail_mask_o  (fail_mask),
        .first_fail_o (first_fail)
    );

    assign o_a          = a_q;
    assign o_b          = b_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_pass       = pass_q;
    assign o_fail_mask  = fail_mask;
    assign o_first_fail = first_fail;

endmodule

// File: tb/tb_quad_gate_bist_ctrl.sv
// Bench for quad_gate_bist_ctrl: two instances (OR/settle 2 and AND/settle 1)
// driven by gate models with injectable stuck-at faults, checked against a
// pattern-level reference model.
module tb_quad_gate_bist_ctrl;
    import quad_gate_bist_ctrl_pkg::*;

    localparam int         S1   = 2;
    localparam logic [3:0] GF1  = FUNC_OR;
    localparam int         S2   = 1;
    localparam logic [3:0] GF2  = FUNC_AND;
    localparam int         LAT1 = 4 * (S1 + 1);
    localparam int         LAT2 = 4 * (S2 + 1);

    logic       clk = 1'b0;
    logic       rst_n, start, abort;
    logic [3:0] a1, b1, y1, fm1, a2, b2, y2, fm2;
    logic [1:0] ff1, ff2;
    logic       busy1, done1, pass1, busy2, done2, pass2;
    logic [3:0] gm1, s0_1, s1_1, gm2, s0_2, s1_2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Gate package model: each channel computes func[{A,B}], then stuck-at faults override.
    function automatic logic [3:0] gate_out(input logic [3:0] f, input logic [3:0] a,
                                            input logic [3:0] b, input logic [3:0] s0,
                                            input logic [3:0] s1);
        logic [3:0] g;
        for (int n = 0; n < 4; n++) g[n] = f[{a[n], b[n]}];
        return (g & ~s0) | s1;
    endfunction

    assign y1 = gate_out(gm1, a1, b1, s0_1, s1_1);
    assign y2 = gate_out(gm2, a2, b2, s0_2, s1_2);

    quad_gate_bist_ctrl #(.SETTLE_CYCLES(S1), .GATE_FUNC(GF1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .o_a(a1), .o_b(b1), .i_y(y1), .o_busy(busy1), .o_done(done1),
        .o_pass(pass1), .o_fail_mask(fm1), .o_first_fail(ff1)
    );

    quad_gate_bist_ctrl #(.SETTLE_CYCLES(S2), .GATE_FUNC(GF2)) dut_and (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .o_a(a2), .o_b(b2), .i_y(y2), .o_busy(busy2), .o_done(done2),
        .o_pass(pass2), .o_fail_mask(fm2), .o_first_fail(ff2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: apply each pattern to the faulty gate model and accumulate the verdict.
    task automatic ref_model(input logic [3:0] gf, input logic [3:0] gm, input logic [3:0] s0,
                             input logic [3:0] s1, output logic [3:0] mask, output logic [1:0] ff);
        logic [3:0] y, mm;
        bit seen;
        mask = 4'h0;
        ff   = 2'b00;
        seen = 1'b0;
        for (int p = 0; p < 4; p++) begin
            y  = gate_out(gm, {4{p[1]}}, {4{p[0]}}, s0, s1);
            mm = y ^ {4{gf[p]}};
            mask |= mm;
            if (mm != 4'h0 && !seen) begin
                ff   = 2'(p);
                seen = 1'b1;
            end
        end
    endtask

    // One full test on both instances; repulse_k re-asserts start for the edge after negedge k.
    task automatic run_test(input string tag, input int repulse_k);
        int k, k1, k2;
        logic [3:0] em1, em2;
        logic [1:0] ef1, ef2;
        ref_model(GF1, gm1, s0_1, s1_1, em1, ef1);
        ref_model(GF2, gm2, s0_2, s1_2, em2, ef2);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq({tag, ":busy_after_start"}, 32'(busy1), 32'd1);
        check_eq({tag, ":done_after_start"}, 32'(done1), 32'd0);
        k  = 0;
        k1 = -1;
        k2 = -1;
        while ((k1 < 0 || k2 < 0) && k < 40) begin
            start = (k == repulse_k);
            @(negedge clk);
            k++;
            if (k1 < 0 && done1) k1 = k;
            if (k2 < 0 && done2) k2 = k;
        end
        start = 1'b0;
        check_eq({tag, ":latency1"}, 32'(k1), 32'(LAT1));
        check_eq({tag, ":latency2"}, 32'(k2), 32'(LAT2));
        check_eq({tag, ":mask1"}, 32'(fm1), 32'(em1));
        check_eq({tag, ":pass1"}, 32'(pass1), 32'(em1 == 4'h0));
        check_eq({tag, ":first1"}, 32'(ff1), 32'(ef1));
        check_eq({tag, ":ab1_idle"}, 32'({a1, b1, busy1}), 32'd0);
        check_eq({tag, ":mask2"}, 32'(fm2), 32'(em2));
        check_eq({tag, ":pass2"}, 32'(pass2), 32'(em2 == 4'h0));
        check_eq({tag, ":first2"}, 32'(ff2), 32'(ef2));
    endtask

    task automatic set_faults(input logic [3:0] g1, input logic [3:0] a0, input logic [3:0] a1v,
                              input logic [3:0] g2, input logic [3:0] c0, input logic [3:0] c1v);
        gm1 = g1; s0_1 = a0; s1_1 = a1v;
        gm2 = g2; s0_2 = c0; s1_2 = c1v;
    endtask

    initial begin
        logic [3:0] funcs [4];
        funcs[0] = FUNC_OR; funcs[1] = FUNC_AND; funcs[2] = FUNC_NAND; funcs[3] = FUNC_NOR;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        set_faults(FUNC_OR, 4'h0, 4'h0, FUNC_AND, 4'h0, 4'h0);

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("reset:ab", 32'({a1, b1}), 32'd0);
        check_eq("reset:flags", 32'({busy1, done1, pass1}), 32'd0);
        check_eq("reset:results", 32'({fm1, ff1}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("idle:flags", 32'({busy1, done1, busy2, done2}), 32'd0);

        // Directed cases from the fault list
        run_test("good", -1);
        repeat (3) @(negedge clk);
        check_eq("good:done_held", 32'({done1, pass1}), 32'b11);
        set_faults(FUNC_OR, 4'b1000, 4'h0, FUNC_AND, 4'h0, 4'h0);
        run_test("ch4_sa0", -1);
        set_faults(FUNC_OR, 4'h0, 4'b0010, FUNC_AND, 4'h0, 4'b0100);
        run_test("ch2_sa1", -1);

        // Randomized faults and wrong-chip substitutions
        for (int i = 0; i < 10; i++) begin
            set_faults(($urandom_range(0, 2) == 0) ? funcs[$urandom_range(0, 3)] : FUNC_OR,
                       4'($urandom) & 4'($urandom), 4'($urandom) & 4'($urandom),
                       ($urandom_range(0, 2) == 0) ? funcs[$urandom_range(0, 3)] : FUNC_AND,
                       4'($urandom) & 4'($urandom), 4'($urandom) & 4'($urandom));
            run_test($sformatf("rand%0d", i), -1);
        end

        // Start re-pulsed during SETTLE of pattern 10 is ignored
        set_faults(FUNC_OR, 4'h0, 4'h0, FUNC_AND, 4'h0, 4'h0);
        run_test("repulse", 7);

        // Abort together with start while in DONE
        @(negedge clk);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check_eq("abort_done:flags", 32'({busy1, done1, pass1}), 32'd0);
        check_eq("abort_done:results", 32'({fm1, ff1, a1, b1}), 32'd0);
        repeat (15) @(negedge clk);
        check_eq("abort_done:stays_idle", 32'({busy1, done1, busy2, done2}), 32'd0);

        // Abort during SETTLE
        set_faults(FUNC_OR, 4'h0, 4'b0001, FUNC_AND, 4'h0, 4'h0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("abort_mid:mask_before", 32'(fm1), 32'b0001);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort_mid:cleared", 32'({busy1, done1, fm1, a1, b1}), 32'd0);

        // Asynchronous reset asserted while in CHECK of pattern 01
        set_faults(FUNC_OR, 4'h0, 4'b0010, FUNC_AND, 4'h0, 4'h0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("rst_mid:pre_state", 32'({busy1, a1, b1, fm1}), 32'({1'b1, 4'h0, 4'hF, 4'b0010}));
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid:ab", 32'({a1, b1}), 32'd0);
        check_eq("rst_mid:busy_mask", 32'({busy1, fm1}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        set_faults(FUNC_OR, 4'h0, 4'h0, FUNC_AND, 4'h0, 4'h0);
        repeat (2) @(negedge clk);
        check_eq("rst_mid:idle_after", 32'({busy1, done1}), 32'd0);
        run_test("after_rst", -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
